jk_bank_sched: RTL and testbench

Scheduler that shares one bank of JK flip-flops (`jkff_2` instances, external to this block) between several requesters. Each requester asks for one JK operation on one flip-flop: hold, reset, set or toggle. Requests are arbitrated round-robin. The scheduler drives the winning j/k pair for exactly one clock, then reads the flip-flop's q back to confirm the result. It sits between control logic and the flip-flop bank, so requesters never drive j/k directly.

---
 rtl/jk_bank_if.sv | 29 ++
 rtl/jk_bank_sched.sv | 155 +++++++++++++++
 tb/tb_jk_bank_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_if.sv
// Requester, flip-flop bank and status signals of the JK bank scheduler.
// The master side issues requests and returns the bank's q; the slave side schedules.
interface jk_bank_if #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IW   = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [IW*NREQ-1:0] idx;
    logic [NREQ-1:0]    gnt;
    logic [NFF-1:0]     j_out;
    logic [NFF-1:0]     k_out;
    logic [NFF-1:0]     q_in;
    logic               busy;
    logic               done;
    logic [IW-1:0]      done_id;
    logic               err;

    modport master (
        output req, op, idx, q_in,
        input  gnt, j_out, k_out, busy, done, done_id, err
    );

    modport slave (
        input  req, op, idx, q_in,
        output gnt, j_out, k_out, busy, done, done_id, err
    );
endinterface

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one JK flip-flop bank between NREQ requesters.
// Each op is driven onto j/k for one cycle, then q is read back and checked.
module jk_bank_sched #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IW   = 3
) (
    input  logic     clk,
    input  logic     reset,
    jk_bank_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, REJECT} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] id_q, id_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          exp_q, exp_d;

    logic          win_vld;
    logic [PW-1:0] win;
    logic [1:0]    win_op;
    logic [IW-1:0] win_idx;
    logic          win_q;
    logic          win_legal;

    logic [NREQ-1:0] gnt_v;
    logic [NFF-1:0]  j_v;
    logic [NFF-1:0]  k_v;
    logic            done_v;
    logic            err_v;

    function automatic logic q_at(input logic [IW-1:0] i,
                                  input logic [NFF-1:0] q);
        logic r;
        r = 1'b0;
        for (int f = 0; f < NFF; f++) begin
            if (i == IW'(f)) r = q[f];
        end
        return r;
    endfunction

    // Outer loop walks the search order, so the first hit is the winner.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!win_vld && bus.req[r] &&
                    ((int'(ptr_q) + k == r) ||
                     (int'(ptr_q) + k == r + NREQ))) begin
                    win_vld = 1'b1;
                    win     = PW'(r);
                end
            end
        end
    end

    always_comb begin
        win_op  = '0;
        win_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win == PW'(r)) begin
                win_op  = bus.op[2*r +: 2];
                win_idx = bus.idx[IW*r +: IW];
            end
        end
        win_legal = (int'(win_idx) < NFF);
        win_q     = win_legal ? q_at(win_idx, bus.q_in) : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        gnt_v   = '0;
        j_v     = '0;
        k_v     = '0;
        done_v  = 1'b0;
        err_v   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld && !reset) begin
                    for (int r = 0; r < NREQ; r++) begin
                        gnt_v[r] = (win == PW'(r));
                    end
                    id_d  = win;
                    op_d  = win_op;
                    idx_d = win_idx;
                    unique case (win_op)
                        2'b00:   exp_d = win_q;
                        2'b01:   exp_d = 1'b0;
                        2'b10:   exp_d = 1'b1;
                        default: exp_d = ~win_q;
                    endcase
                    if (int'(win) == NREQ - 1) ptr_d = '0;
                    else                       ptr_d = win + 1'b1;
                    state_d = win_legal ? DRIVE : REJECT;
                end
            end
            DRIVE: begin
                for (int f = 0; f < NFF; f++) begin
                    if (idx_q == IW'(f)) begin
                        j_v[f] = op_q[1];
                        k_v[f] = op_q[0];
                    end
                end
                state_d = CHECK;
            end
            CHECK: begin
                done_v  = 1'b1;
                err_v   = (q_at(idx_q, bus.q_in) != exp_q);
                state_d = IDLE;
            end
            REJECT: begin
                done_v  = 1'b1;
                err_v   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
        end
    end

    assign bus.gnt     = gnt_v;
    assign bus.j_out   = j_v;
    assign bus.k_out   = k_v;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_v;
    assign bus.err     = err_v;
    assign bus.done_id = IW'(id_q);
endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed vector table, reset abort sequence,
// then random traffic against a timeline model of the scheduler and the bank.
module tb_jk_bank_sched;
    localparam int NREQ = 4;
    localparam int NFF  = 6;
    localparam int IW   = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NFF-1:0] bank_q = '0;
    logic [NFF-1:0] stuck  = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jk_bank_if #(.NREQ(NREQ), .NFF(NFF), .IW(IW)) bus ();

    jk_bank_sched #(.NREQ(NREQ), .NFF(NFF), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural JK bank; stuck bits force q low to fake a readback fault.
    always @(posedge clk) begin
        for (int f = 0; f < NFF; f++) begin
            case ({bus.j_out[f], bus.k_out[f]})
                2'b01:   bank_q[f] <= 1'b0;
                2'b10:   bank_q[f] <= 1'b1;
                2'b11:   bank_q[f] <= ~bank_q[f];
                default: bank_q[f] <= bank_q[f];
            endcase
        end
    end
    assign bus.q_in = bank_q & ~stuck;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [11:0] idx;
        logic [5:0]  stuck;
        logic [3:0]  gnt;
        logic [5:0]  j;
        logic [5:0]  k;
        logic        busy;
        logic        done;
        logic        err;
        logic [2:0]  id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] req, input logic [7:0] op,
                       input logic [11:0] idx, input logic [5:0] stk,
                       input logic [3:0] gnt, input logic [5:0] j,
                       input logic [5:0] k, input logic busy,
                       input logic done, input logic err,
                       input logic [2:0] id);
        vec_t v;
        v.req = req; v.op = op; v.idx = idx; v.stuck = stk;
        v.gnt = gnt; v.j = j; v.k = k; v.busy = busy;
        v.done = done; v.err = err; v.id = id;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic jk_result(input logic [1:0] op, input logic q);
        case (op)
            2'd0:    return q;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~q;
        endcase
    endfunction

    localparam logic [7:0]  OA = 8'b00_11_10_10;
    localparam logic [11:0] IA = {3'd4, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0]  OB = 8'b00_00_00_10;
    localparam logic [11:0] IB = {3'd4, 3'd0, 3'd0, 3'd3};
    localparam logic [7:0]  OC = 8'b00_00_00_11;
    localparam logic [7:0]  OD = 8'b00_00_00_01;
    localparam logic [7:0]  OE = 8'b00_00_00_00;
    localparam logic [11:0] IE = {3'd4, 3'd2, 3'd0, 3'd0};
    localparam logic [7:0]  OF = 8'b00_00_01_01;
    localparam logic [7:0]  OG = 8'b00_10_00_00;
    localparam logic [11:0] IG = {3'd4, 3'd7, 3'd1, 3'd0};
    localparam logic [7:0]  OH = 8'b00_00_10_00;
    localparam logic [11:0] IH = {3'd4, 3'd0, 3'd5, 3'd0};

    initial begin
        int cyc, free_at, drive_at, done_at, ptr, w;
        int p_id, p_idx;
        logic [1:0] p_op;
        logic p_exp, p_legal;
        logic [NREQ-1:0] last_gnt, e_gnt;
        logic [NFF-1:0] e_j, e_k;
        logic e_done;

        // Round-robin 0..3, then 1001 from pointer 0
        add(4'b1111, OA, IA, 6'h00, 4'b0001, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b1110, OA, IA, 6'h00, 4'b0000, 6'h01, 6'h00, 1, 0, 0, 0);
        add(4'b1110, OA, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 0);
        add(4'b1110, OA, IA, 6'h00, 4'b0010, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b1100, OA, IA, 6'h00, 4'b0000, 6'h02, 6'h00, 1, 0, 0, 0);
        add(4'b1100, OA, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 1);
        add(4'b1100, OA, IA, 6'h00, 4'b0100, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b1000, OA, IA, 6'h00, 4'b0000, 6'h04, 6'h04, 1, 0, 0, 0);
        add(4'b1000, OA, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 2);
        add(4'b1000, OA, IA, 6'h00, 4'b1000, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OA, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 0, 0, 0);
        add(4'b0000, OA, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 3);
        add(4'b1001, OB, IB, 6'h00, 4'b0001, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b1000, OB, IB, 6'h00, 4'b0000, 6'h08, 6'h00, 1, 0, 0, 0);
        add(4'b1000, OB, IB, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 0);
        add(4'b1000, OB, IB, 6'h00, 4'b1000, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OB, IB, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 0, 0, 0);
        add(4'b0000, OB, IB, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 3);
        // Toggle then reset on idx 3
        add(4'b0001, OC, IB, 6'h00, 4'b0001, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OC, IB, 6'h00, 4'b0000, 6'h08, 6'h08, 1, 0, 0, 0);
        add(4'b0000, OC, IB, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 0);
        add(4'b0001, OD, IB, 6'h00, 4'b0001, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OD, IB, 6'h00, 4'b0000, 6'h00, 6'h08, 1, 0, 0, 0);
        add(4'b0000, OD, IB, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 0);
        // Move pointer to 3, then wrap 3,0,1
        add(4'b0100, OE, IE, 6'h00, 4'b0100, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OE, IE, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 0, 0, 0);
        add(4'b0000, OE, IE, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 2);
        add(4'b1011, OF, IA, 6'h00, 4'b1000, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0011, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 0, 0, 0);
        add(4'b0011, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 3);
        add(4'b0011, OF, IA, 6'h00, 4'b0001, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0010, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h01, 1, 0, 0, 0);
        add(4'b0010, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 0);
        add(4'b0010, OF, IA, 6'h00, 4'b0010, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h02, 1, 0, 0, 0);
        add(4'b0000, OF, IA, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 0, 1);
        // Illegal index 7 on a 6-deep bank
        add(4'b0100, OG, IG, 6'h00, 4'b0100, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OG, IG, 6'h00, 4'b0000, 6'h00, 6'h00, 1, 1, 1, 2);
        add(4'b0000, OG, IG, 6'h00, 4'b0000, 6'h00, 6'h00, 0, 0, 0, 0);
        // Readback fault: q[5] held low during a set
        add(4'b0010, OH, IH, 6'h20, 4'b0010, 6'h00, 6'h00, 0, 0, 0, 0);
        add(4'b0000, OH, IH, 6'h20, 4'b0000, 6'h20, 6'h00, 1, 0, 0, 0);
        add(4'b0000, OH, IH, 6'h20, 4'b0000, 6'h00, 6'h00, 1, 1, 1, 1);
        add(4'b0000, OH, IH, 6'h00, 4'b0000, 6'h00, 6'h00, 0, 0, 0, 0);

        reset   = 1'b1;
        bus.req = '1;
        bus.op  = OA;
        bus.idx = IA;
        @(negedge clk);
        check("rst gnt", bus.gnt, 0);
        check("rst j", bus.j_out, 0);
        check("rst k", bus.k_out, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst err", bus.err, 0);
        check("rst id", bus.done_id, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.req = '0;

        foreach (tbl[n]) begin
            @(posedge clk);
            #1;
            bus.req = tbl[n].req;
            bus.op  = tbl[n].op;
            bus.idx = tbl[n].idx;
            stuck   = tbl[n].stuck;
            @(negedge clk);
            check($sformatf("row%0d gnt", n), bus.gnt, tbl[n].gnt);
            check($sformatf("row%0d j", n), bus.j_out, tbl[n].j);
            check($sformatf("row%0d k", n), bus.k_out, tbl[n].k);
            check($sformatf("row%0d busy", n), bus.busy, tbl[n].busy);
            check($sformatf("row%0d done", n), bus.done, tbl[n].done);
            check($sformatf("row%0d err", n), bus.err, tbl[n].err);
            if (tbl[n].done)
                check($sformatf("row%0d id", n), bus.done_id, tbl[n].id);
        end

        // Reset in the middle of DRIVE for a set on idx 2
        @(posedge clk);
        #1;
        bus.req = 4'b0001;
        bus.op  = 8'b00_00_00_10;
        bus.idx = {3'd0, 3'd0, 3'd0, 3'd2};
        @(negedge clk);
        check("abort gnt", bus.gnt, 4'b0001);
        @(posedge clk);
        #1;
        bus.req = '0;
        @(negedge clk);
        check("abort drive j", bus.j_out, 6'h04);
        #1;
        reset = 1'b1;
        #1;
        check("abort j", bus.j_out, 0);
        check("abort k", bus.k_out, 0);
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort no done %0d", i), bus.done, 0);
            check($sformatf("abort idle %0d", i), bus.busy, 0);
        end
        @(posedge clk);
        #1;
        bus.req = 4'b1001;
        bus.op  = 8'b00_00_00_00;
        bus.idx = {3'd1, 3'd0, 3'd0, 3'd0};
        @(negedge clk);
        check("abort ptr0 gnt", bus.gnt, 4'b0001);
        @(posedge clk);
        #1;
        bus.req = '0;

        // Random traffic against a grant/done timeline model
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset    = 1'b0;
        cyc      = 0;
        free_at  = 0;
        drive_at = -1;
        done_at  = -1;
        ptr      = 0;
        p_id     = 0;
        p_idx    = 0;
        p_op     = 0;
        p_exp    = 0;
        p_legal  = 0;
        last_gnt = '0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (last_gnt[r]) begin
                    bus.req[r] = 1'b0;
                end else if (!bus.req[r] && $urandom_range(0, 2) == 0) begin
                    bus.req[r]            = 1'b1;
                    bus.op[2*r +: 2]      = 2'($urandom_range(0, 3));
                    bus.idx[IW*r +: IW]   = 3'($urandom_range(0, 7));
                end
            end
            @(negedge clk);
            w = -1;
            if (cyc >= free_at) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && bus.req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
                end
            end
            e_gnt = '0;
            if (w >= 0) e_gnt[w] = 1'b1;
            e_j = '0;
            e_k = '0;
            if (cyc == drive_at) begin
                e_j[p_idx] = p_op[1];
                e_k[p_idx] = p_op[0];
            end
            e_done = (cyc == done_at);
            check($sformatf("rnd%0d gnt", cyc), bus.gnt, e_gnt);
            check($sformatf("rnd%0d j", cyc), bus.j_out, e_j);
            check($sformatf("rnd%0d k", cyc), bus.k_out, e_k);
            check($sformatf("rnd%0d busy", cyc), bus.busy, cyc < free_at);
            check($sformatf("rnd%0d done", cyc), bus.done, e_done);
            check($sformatf("rnd%0d err", cyc), bus.err, e_done && !p_legal);
            if (e_done) begin
                check($sformatf("rnd%0d id", cyc), bus.done_id, p_id);
                if (p_legal)
                    check($sformatf("rnd%0d bank q", cyc), bus.q_in[p_idx], p_exp);
            end
            last_gnt = bus.gnt;
            if (w >= 0) begin
                p_id    = w;
                p_op    = bus.op[2*w +: 2];
                p_idx   = int'(bus.idx[IW*w +: IW]);
                p_legal = (p_idx < NFF);
                p_exp   = p_legal ? jk_result(p_op, bus.q_in[p_idx]) : 1'b0;
                if (p_legal) begin
                    drive_at = cyc + 1;
                    done_at  = cyc + 2;
                end else begin
                    drive_at = -1;
                    done_at  = cyc + 1;
                end
                free_at = done_at + 1;
                ptr     = (w + 1) % NREQ;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.req = '0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
